regfile_scoreboard: RTL and testbench

Parametrised integer register file for the pipelined RISC-V core, adding per-register scoreboard (busy) bits, a configurable number of read ports and same-cycle writeback bypass. Decode issues destination registers, which are marked busy. Writeback writes the data and clears the busy bit. Read ports return data plus a per-port hazard flag, so the hazard unit can stall without its own tracking logic.

---
 rtl/regfile_scoreboard_pkg.sv | 8 +
 rtl/regfile_scoreboard_sb.sv | 46 ++++
 rtl/regfile_scoreboard.sv | 55 +++++
 tb/tb_regfile_scoreboard.sv | 133 +++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// rv_pkg: shared register-file widths, address/data types and the x0 index.
package rv_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREGS_DEFAULT = 32;
  typedef logic [4:0] reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xword_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard_sb.sv
// rf_scoreboard: per-register busy bits, their population count and issue acceptance.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec,
  output logic [AW:0]      busy_cnt
);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0] cnt_q, cnt_d;
  logic accept;
  assign issue_ready = (issue_rd == ZERO) || !busy_q[issue_rd] || (wb_valid && wb_addr == issue_rd);
  assign accept = issue_valid && issue_ready && !flush;
  // Later assignments take priority: writeback clear, then issue set, then flush.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (accept) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NREGS; i++) cnt_d = cnt_d + {{AW{1'b0}}, busy_d[i]};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with scoreboard busy bits and writeback bypass.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW = $clog2(NREGS),
  parameter int NRD = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec,
  output logic [AW:0]         busy_cnt
);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);
  logic [XLEN-1:0] rf_q [NREGS];
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_valid && wb_addr != ZERO) begin
      rf_q[wb_addr] <= wb_data;
    end
  end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic hit;
    assign addr = rd_addr[i*AW +: AW];
    assign hit = (BYPASS != 0) && wb_valid && wb_addr == addr && addr != ZERO;
    assign rd_data[i*XLEN +: XLEN] = (addr == ZERO) ? '0 : hit ? wb_data : rf_q[addr];
    assign rd_busy[i] = (addr != ZERO) && !hit && busy_vec[addr];
  end
  rf_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .flush(flush),
    .busy_vec(busy_vec),
    .busy_cnt(busy_cnt)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios then random traffic against an array-based model.
module tb_regfile_scoreboard;
  localparam int XLEN = 32, NREGS = 32, AW = 5, NRD = 2, BYPASS = 1;
  logic clk = 0, rst = 0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic issue_valid = 0, issue_ready, wb_valid = 0, flush = 0;
  logic [AW-1:0] issue_rd = '0, wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic [NREGS-1:0] busy_vec;
  logic [AW:0] busy_cnt;
  int checks = 0, errors = 0;
  logic [XLEN-1:0] m_rf [NREGS];
  bit m_busy [NREGS];
  bit armed = 0;
  logic [XLEN-1:0] obs_d0;
  logic obs_b0, obs_rdy;
  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(BYPASS)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic r, input logic iv, input logic [4:0] ird, input logic wv,
                       input logic [4:0] wa, input logic [31:0] wd, input logic fl,
                       input logic [4:0] a0, input logic [4:0] a1);
    logic [4:0] a;
    logic [31:0] ed;
    logic eb, erdy;
    logic [NREGS-1:0] ev;
    int ec;
    rst = r; issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_addr = wa; wb_data = wd;
    flush = fl; rd_addr = {a1, a0};
    @(negedge clk);
    erdy = (ird == 0) || !m_busy[ird] || (wv && wa == ird);
    if (armed) begin
      for (int p = 0; p < NRD; p++) begin
        a = (p == 0) ? a0 : a1;
        if (a == 0) begin ed = 0; eb = 0; end
        else if (BYPASS != 0 && wv && wa == a) begin ed = wd; eb = 0; end
        else begin ed = m_rf[a]; eb = m_busy[a]; end
        check($sformatf("rd_data%0d x%0d", p, a), rd_data[p*XLEN +: XLEN], ed);
        check($sformatf("rd_busy%0d x%0d", p, a), rd_busy[p], eb);
      end
      check($sformatf("issue_ready x%0d", ird), issue_ready, erdy);
    end
    obs_d0 = rd_data[XLEN-1:0]; obs_b0 = rd_busy[0]; obs_rdy = issue_ready;
    if (!r) begin
      for (int i = 0; i < NREGS; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
    end else begin
      if (wv && wa != 0) m_rf[wa] = wd;
      if (fl) for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
      else begin
        if (wv) m_busy[wa] = 0;
        if (iv && erdy && ird != 0) m_busy[ird] = 1;
      end
    end
    @(posedge clk); #1;
    ev = '0; ec = 0;
    for (int i = 0; i < NREGS; i++) begin ev[i] = m_busy[i]; ec += int'(m_busy[i]); end
    check("busy_vec", busy_vec, ev);
    check("busy_cnt", busy_cnt, ec);
    armed = 1;
  endtask
  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    cycle(1, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask
  initial begin
    cycle(0, 0, 0, 0, 0, 0, 0, 5, 31);
    cycle(0, 0, 0, 0, 0, 0, 0, 5, 31);
    idle(5, 31);
    check("reset x5", obs_d0, 0);
    check("reset busy", obs_b0, 0);
    cycle(1, 0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 0);
    check("bypass x5", obs_d0, 32'hDEADBEEF);
    idle(5, 5);
    check("stored x5", obs_d0, 32'hDEADBEEF);
    cycle(1, 1, 7, 0, 0, 0, 0, 7, 0);
    check("cnt after issue x7", busy_cnt, 1);
    cycle(1, 1, 7, 0, 0, 0, 0, 7, 7);
    check("x7 busy", obs_b0, 1);
    check("x7 ready low", obs_rdy, 0);
    cycle(1, 0, 0, 1, 7, 32'h12, 0, 7, 0);
    check("x7 wb busy", obs_b0, 0);
    check("x7 wb data", obs_d0, 32'h12);
    check("x7 cleared cnt", busy_cnt, 0);
    cycle(1, 1, 9, 0, 0, 0, 0, 9, 0);
    cycle(1, 1, 9, 1, 9, 32'h55, 0, 9, 0);
    check("x9 waw ready", obs_rdy, 1);
    check("x9 busy kept", busy_vec[9], 1);
    idle(9, 0);
    check("x9 data", obs_d0, 32'h55);
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 32'hFFFF, 0, 0, 0);
    check("x0 issue ready", obs_rdy, 1);
    idle(0, 0);
    check("x0 read", obs_d0, 0);
    check("x0 busy_vec", busy_vec, 0);
    cycle(1, 1, 3, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 4, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 10, 0, 0, 0, 0, 0, 0);
    check("three busy", busy_cnt, 3);
    cycle(1, 1, 5, 1, 3, 32'hAA, 1, 0, 0);
    check("flush vec", busy_vec, 0);
    idle(3, 0);
    check("x3 after flush", obs_d0, 32'hAA);
    cycle(1, 1, 3, 0, 0, 0, 0, 3, 0);
    cycle(0, 1, 4, 1, 6, 32'h77, 0, 3, 0);
    check("reset cnt", busy_cnt, 0);
    idle(3, 6);
    check("x3 after reset", obs_d0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] ird, wa, a0, a1;
      ird = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wa  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a0  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      a1  = 5'($urandom);
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 1) != 0, ird,
            $urandom_range(0, 2) != 0, wa, $urandom, $urandom_range(0, 19) == 0, a0, a1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
